extend_arbiter: RTL

Round-robin arbiter and sequencer that shares one pipelined sign/zero-extend unit among REQ requesters. It accepts one request per cycle, drives the unit's input and sign-mode select, and tracks requester IDs through the unit's fixed latency. It routes each result back to the requester that issued it. It sits between the decode-side consumers, such as immediate and load-byte/halfword paths, and a single Arith extend instance.

---
 rtl/extend_arbiter_if.sv | 29 ++
 rtl/extend_arbiter.sv | 84 ++++++++
 2 files changed

// File: rtl/extend_arbiter_if.sv
// Request/response and extend-unit bundle for extend_arbiter.
// slave = arbiter side, master = requesters plus the extend unit.
interface extend_arbiter_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int REQ   = 2
);
  logic [REQ-1:0]           req_valid;
  logic [REQ-1:0][IN_W-1:0] req_data;
  logic [REQ-1:0]           req_sign;
  logic [REQ-1:0]           req_ready;
  logic                     flush;
  logic [IN_W-1:0]          ext_in;
  logic                     ext_sign;
  logic [OUT_W-1:0]         ext_out;
  logic [REQ-1:0]           rsp_valid;
  logic [OUT_W-1:0]         rsp_data;
  logic                     busy;

  modport slave (
    input  req_valid, req_data, req_sign, flush, ext_out,
    output req_ready, ext_in, ext_sign, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_data, req_sign, flush, ext_out,
    input  req_ready, ext_in, ext_sign, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/extend_arbiter.sv
// Round-robin sharing of one fixed-latency sign/zero-extend unit among REQ requesters,
// with requester IDs carried alongside the unit's pipeline to route results back.
module extend_arbiter #(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 8,
  parameter int LAT     = 2,
  parameter int REQ     = 2,
  parameter int MAX_OUT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  extend_arbiter_if.slave  bus
);
  localparam int   PW            = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int   CW            = $clog2(MAX_OUT + 1);
  localparam logic SIGN_UNSIGNED = 1'b0;

  logic [PW-1:0]           ptr_q, ptr_d;
  logic [LAT-1:0]          tag_v_q;
  logic [LAT-1:0][PW-1:0]  tag_id_q;
  logic [REQ-1:0][CW-1:0]  outst_q, outst_d;
  logic [REQ-1:0]          elig, grant_oh, rsp_oh;
  logic                    grant;
  logic [PW-1:0]           gid, idx;

  // A response retiring this cycle frees its slot for a same-cycle grant.
  // Gating with rst_ni keeps req_ready low while reset is held.
  always_comb begin
    for (int i = 0; i < REQ; i++) begin
      rsp_oh[i] = tag_v_q[LAT-1] && (tag_id_q[LAT-1] == PW'(i));
      elig[i]   = rst_ni && !bus.flush && bus.req_valid[i] &&
                  ((outst_q[i] - CW'(rsp_oh[i])) < CW'(MAX_OUT));
    end
  end

  always_comb begin
    grant    = 1'b0;
    gid      = '0;
    idx      = '0;
    grant_oh = '0;
    for (int k = 0; k < REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % REQ);
      if (!grant && elig[idx]) begin
        grant = 1'b1;
        gid   = idx;
      end
    end
    if (grant) grant_oh[gid] = 1'b1;
  end

  always_comb begin
    bus.req_ready = grant_oh;
    bus.ext_in    = grant ? bus.req_data[gid] : '0;
    bus.ext_sign  = grant ? bus.req_sign[gid] : SIGN_UNSIGNED;
    bus.rsp_valid = rsp_oh;
    bus.rsp_data  = (|rsp_oh) ? bus.ext_out : '0;
    bus.busy      = |tag_v_q;
  end

  always_comb begin
    ptr_d = grant ? PW'((int'(gid) + 1) % REQ) : ptr_q;
    for (int i = 0; i < REQ; i++) begin
      outst_d[i] = bus.flush ? '0 : outst_q[i] + CW'(grant_oh[i]) - CW'(rsp_oh[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
      outst_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      outst_q     <= outst_d;
      tag_v_q[0]  <= grant && !bus.flush;
      tag_id_q[0] <= gid;
      for (int s = 1; s < LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1] && !bus.flush;
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end
endmodule
